// File: rtl/fc_layer_engine.sv
// Fully-connected layer sequencer: streams weight/activation chunks through an
// external MultAdder, accumulates, adds bias, requantises and packs results to RAM.
module fc_layer_engine #(
  parameter int unsigned N_IN      = 784,
  parameter int unsigned N_OUT     = 10,
  parameter int unsigned VEC       = 128,
  parameter int unsigned EW        = 8,
  parameter int unsigned PW        = 15,
  parameter int unsigned AW        = 24,
  parameter int unsigned SHIFT     = 7,
  parameter int unsigned MA_LAT    = 1,
  parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
  parameter logic [31:0] IN_BASE   = 32'h0000_1000,
  parameter logic [31:0] BIAS_BASE = 32'h0000_2000,
  parameter logic [31:0] OUT_BASE  = 32'h0000_3000
) (
  input  logic                clk,
  input  logic                iRst,
  input  logic                start,
  input  logic                relu_en,
  input  logic [VEC*EW-1:0]   data_from_rom,
  input  logic [VEC*EW-1:0]   data_from_ram,
  input  logic [PW-1:0]       data_from_MultAdder,
  input  logic                overflow_from_MultAdder,
  output logic [31:0]         addr_to_rom,
  output logic [31:0]         addr_to_ram,
  output logic                ram_we,
  output logic [VEC*EW-1:0]   data_to_ram,
  output logic [VEC*EW-1:0]   opr1_to_MultAdder,
  output logic [VEC*EW-1:0]   opr2_to_MultAdder,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  localparam int unsigned DW   = VEC * EW;
  localparam int unsigned CH   = (N_IN + VEC - 1) / VEC;
  localparam int unsigned LAST = N_IN - (CH - 1) * VEC;
  localparam int unsigned G    = (N_OUT + VEC - 1) / VEC;
  localparam int unsigned RW   = $clog2(N_OUT + 1);
  localparam int unsigned CW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned LW   = (VEC > 1) ? $clog2(VEC) : 1;
  localparam int unsigned GW   = $clog2(G + 1);
  localparam int unsigned WW   = $clog2(MA_LAT + 1);
  localparam int unsigned TW   = AW + 2;
  localparam logic signed [TW-1:0] SMAX = TW'((2 ** (EW - 1)) - 1);
  localparam logic signed [TW-1:0] SMIN = ~SMAX;

  typedef enum logic [3:0] {
    IDLE, BREQ, BGET, ASK, GET, WAITMA, ACC, FIN, WR, DONE
  } state_t;

  state_t state, state_n;

  logic [RW-1:0]        r, r_n;
  logic [CW-1:0]        c, c_n;
  logic [LW-1:0]        lane, lane_n;
  logic [GW-1:0]        g, g_n;
  logic [WW-1:0]        wcnt, wcnt_n;
  logic [31:0]          rbase, rbase_n;
  logic signed [AW-1:0] acc, acc_n;
  logic [DW-1:0]        bias_q, bias_n;
  logic                 relu_q, relu_n;

  logic [31:0]          rom_addr_n, ram_addr_n;
  logic                 we_n, busy_n, done_n, ovf_n;
  logic [DW-1:0]        wdata_n, opr1_n, opr2_n;

  logic signed [AW-1:0] ma_ext, acc_sum;
  logic                 add_ovf;
  logic signed [EW-1:0] bias_lane;
  logic signed [TW-1:0] fin_sum, fin_sh;
  logic [EW-1:0]        res;
  logic                 sat_ovf;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (iRst) begin
      state             <= IDLE;
      r                 <= '0;
      c                 <= '0;
      lane              <= '0;
      g                 <= '0;
      wcnt              <= '0;
      rbase             <= '0;
      acc               <= '0;
      bias_q            <= '0;
      relu_q            <= 1'b0;
      addr_to_rom       <= '0;
      addr_to_ram       <= '0;
      ram_we            <= 1'b0;
      data_to_ram       <= '0;
      opr1_to_MultAdder <= '0;
      opr2_to_MultAdder <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      overflow          <= 1'b0;
    end else begin
      state             <= state_n;
      r                 <= r_n;
      c                 <= c_n;
      lane              <= lane_n;
      g                 <= g_n;
      wcnt              <= wcnt_n;
      rbase             <= rbase_n;
      acc               <= acc_n;
      bias_q            <= bias_n;
      relu_q            <= relu_n;
      addr_to_rom       <= rom_addr_n;
      addr_to_ram       <= ram_addr_n;
      ram_we            <= we_n;
      data_to_ram       <= wdata_n;
      opr1_to_MultAdder <= opr1_n;
      opr2_to_MultAdder <= opr2_n;
      busy              <= busy_n;
      done              <= done_n;
      overflow          <= ovf_n;
    end
  end

  // Next-state, counters and output next-values
  always_comb begin
    state_n    = state;
    r_n        = r;
    c_n        = c;
    lane_n     = lane;
    g_n        = g;
    wcnt_n     = wcnt;
    rbase_n    = rbase;
    acc_n      = acc;
    bias_n     = bias_q;
    relu_n     = relu_q;
    rom_addr_n = addr_to_rom;
    ram_addr_n = addr_to_ram;
    we_n       = 1'b0;
    wdata_n    = data_to_ram;
    opr1_n     = opr1_to_MultAdder;
    opr2_n     = opr2_to_MultAdder;
    busy_n     = busy;
    done_n     = done;
    ovf_n      = overflow;

    ma_ext  = AW'($signed(data_from_MultAdder));
    acc_sum = acc + ma_ext;
    add_ovf = (acc[AW-1] == ma_ext[AW-1]) && (acc_sum[AW-1] != acc[AW-1]);

    bias_lane = '0;
    for (int unsigned i = 0; i < VEC; i++) begin
      if (lane == LW'(i)) bias_lane = bias_q[i*EW +: EW];
    end
    fin_sum = TW'(acc) + TW'(bias_lane);
    fin_sh  = fin_sum >>> SHIFT;
    sat_ovf = 1'b0;
    // ReLU clamp takes precedence so a clamped negative never flags overflow
    if (relu_q && fin_sh[TW-1]) begin
      res = '0;
    end else if (fin_sh > SMAX) begin
      res     = EW'(SMAX);
      sat_ovf = 1'b1;
    end else if (fin_sh < SMIN) begin
      res     = EW'(SMIN);
      sat_ovf = 1'b1;
    end else begin
      res = EW'(fin_sh);
    end

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n  = BREQ;
          done_n   = 1'b0;
          ovf_n    = 1'b0;
          r_n      = '0;
          c_n      = '0;
          g_n      = '0;
          lane_n   = '0;
          rbase_n  = '0;
          acc_n    = '0;
          relu_n   = relu_en;
          busy_n   = 1'b1;
        end
      end
      BREQ: state_n = BGET;
      BGET: begin
        bias_n  = data_from_ram;
        state_n = ASK;
      end
      ASK: state_n = GET;
      GET: begin
        for (int unsigned i = 0; i < VEC; i++) begin
          if ((c == CW'(CH - 1)) && (i >= LAST)) begin
            opr1_n[i*EW +: EW] = '0;
            opr2_n[i*EW +: EW] = '0;
          end else begin
            opr1_n[i*EW +: EW] = data_from_ram[i*EW +: EW];
            opr2_n[i*EW +: EW] = data_from_rom[i*EW +: EW];
          end
        end
        wcnt_n  = '0;
        state_n = WAITMA;
      end
      WAITMA: begin
        if (wcnt == WW'(MA_LAT - 1)) state_n = ACC;
        else                         wcnt_n  = wcnt + WW'(1);
      end
      ACC: begin
        acc_n = acc_sum;
        ovf_n = overflow | overflow_from_MultAdder | add_ovf;
        if (c != CW'(CH - 1)) begin
          c_n     = c + CW'(1);
          state_n = ASK;
        end else begin
          c_n     = '0;
          state_n = FIN;
        end
      end
      FIN: begin
        for (int unsigned i = 0; i < VEC; i++) begin
          if (lane == LW'(i)) wdata_n[i*EW +: EW] = res;
        end
        ovf_n   = overflow | sat_ovf;
        acc_n   = '0;
        r_n     = r + RW'(1);
        rbase_n = rbase + 32'(CH);
        lane_n  = (lane == LW'(VEC - 1)) ? '0 : lane + LW'(1);
        state_n = ((lane == LW'(VEC - 1)) || (r_n == RW'(N_OUT))) ? WR : ASK;
      end
      WR: begin
        wdata_n = '0;
        g_n     = g + GW'(1);
        if (r == RW'(N_OUT)) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          state_n = BREQ;
        end
      end
      default: state_n = IDLE;
    endcase

    // Addresses are registered on entry so memory data lands in the following state
    if (state_n == BREQ) ram_addr_n = BIAS_BASE + 32'(g_n);
    if (state_n == ASK) begin
      rom_addr_n = ROM_BASE + rbase_n + 32'(c_n);
      ram_addr_n = IN_BASE + 32'(c_n);
    end
    if (state_n == WR) begin
      ram_addr_n = OUT_BASE + 32'(g_n);
      we_n       = 1'b1;
    end
  end

endmodule
